// File: rtl/riscv_pkg.sv
// Shared constants and types for the RV32I pipeline front end.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        RUN,
        DRAIN
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset, then flush, then stall, then load, else bubble.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            load_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);

    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic            valid_q, valid_d;

    always_comb begin
        // NOTE: every next-state signal gets its default first so no path leaves it unassigned (no latch).
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (stall_i) begin
            // hold every field
        end else if (load_i) begin
            instr_d    = instr_i;
            pc_d       = pc_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
        end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (!rst) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem request handshake with wait states, redirect drain FSM.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            req_q;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_pc;
    logic            fire;
    logic            load_d;

    assign fire        = req_q & imem_ready;
    assign pc_plus4    = pcf_q + XLEN'(4);
    assign redirect_pc = {PCTargetE[XLEN-1:2], 2'b00};

    always_comb begin
        state_d  = state_q;
        pcf_d    = pcf_q;
        target_d = target_q;
        unique case (state_q)
            RUN: begin
                if (PCSrcE && fire) begin
                    pcf_d = redirect_pc;
                end else if (PCSrcE) begin
                    // The in-flight request cannot be retracted, so park the target until it lands.
                    target_d = redirect_pc;
                    state_d  = DRAIN;
                end else if (StallF) begin
                    pcf_d = pcf_q;
                end else if (fire) begin
                    pcf_d = pc_plus4;
                end
            end
            DRAIN: begin
                if (PCSrcE) target_d = redirect_pc;
                if (fire) begin
                    pcf_d   = PCSrcE ? redirect_pc : target_q;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign load_d = (state_q == RUN) && fire && !PCSrcE && !StallF;

    always_ff @(posedge clk) begin
        // NOTE: the saved target is reset too, so a redirect pending at reset can never resurface.
        if (!rst) begin
            state_q  <= RUN;
            pcf_q    <= RESET_PC;
            target_q <= '0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcf_q    <= pcf_d;
            target_q <= target_d;
            req_q    <= 1'b1;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pcf_q;

    if_id_reg #(.XLEN(XLEN)) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (FlushD),
        .stall_i    (StallD),
        .load_i     (load_d),
        .instr_i    (imem_rdata),
        .pc_i       (pcf_q),
        .pc_plus4_i (pc_plus4),
        .instr_o    (InstrD),
        .pc_o       (PCD),
        .pc_plus4_o (PCPlus4D),
        .valid_o    (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage against a zero/variable-wait instruction memory.
module tb_fetch_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory image: each word encodes its own address so InstrD identifies where it came from.
    assign imem_rdata = 32'h1000_0000 | imem_addr;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    typedef struct {
        logic        rst, sf, sd, fd, src;
        logic [31:0] tgt;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pcd, p4;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, sf, sd, fd, src, input logic [31:0] tgt, input logic rdy,
                       input logic req, input logic [31:0] addr, input logic v,
                       input logic [31:0] pcd, input logic [31:0] p4);
        vec_t e;
        e.rst = r; e.sf = sf; e.sd = sd; e.fd = fd; e.src = src; e.tgt = tgt; e.rdy = rdy;
        e.req = req; e.addr = addr; e.v = v; e.pcd = pcd; e.p4 = p4;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst === 1'b1 && StallF === 1'b1 && StallD === 1'b0) begin
            errors++;
            $display("FAIL hazard_illegal actual=StallF1_StallD0 expected=StallD_with_StallF");
        end
    end

    initial begin
        logic [31:0] exp_instr;
        logic [31:0] held_addr;
        bit          seen;

        rst = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
        PCTargetE = '0; imem_ready = 1'b1;

        //   rst sf sd fd src target        rdy | req addr          v  pcd           p4
        add(1, 0, 0, 0, 0, 32'h0,          1,   0, 32'h0,         0, 32'h0,        32'h0);        // reset state
        add(1, 0, 0, 0, 0, 32'h0,          1,   1, 32'h0,         0, 32'h0,        32'h0);
        add(1, 0, 0, 0, 0, 32'h0,          1,   1, 32'h4,         1, 32'h0,        32'h4);
        add(1, 0, 0, 0, 0, 32'h0,          1,   1, 32'h8,         1, 32'h4,        32'h8);
        add(1, 0, 0, 0, 0, 32'h0,          1,   1, 32'hC,         1, 32'h8,        32'hC);
        add(1, 1, 1, 0, 0, 32'h0,          1,   1, 32'h10,        1, 32'hC,        32'h10);       // stall x2
        add(1, 1, 1, 0, 0, 32'h0,          1,   1, 32'h10,        1, 32'hC,        32'h10);
        add(1, 0, 0, 0, 0, 32'h0,          1,   1, 32'h10,        1, 32'hC,        32'h10);
        add(1, 0, 0, 0, 0, 32'h0,          1,   1, 32'h14,        1, 32'h10,       32'h14);
        add(1, 0, 0, 0, 0, 32'h0,          1,   1, 32'h18,        1, 32'h14,       32'h18);
        add(1, 0, 0, 0, 0, 32'h0,          1,   1, 32'h1C,        1, 32'h18,       32'h1C);
        add(1, 0, 0, 1, 1, 32'h103,        1,   1, 32'h20,        1, 32'h1C,       32'h20);       // redirect, low bits masked
        add(1, 0, 0, 0, 0, 32'h0,          1,   1, 32'h100,       0, 32'h1C,       32'h20);
        add(1, 0, 0, 1, 1, 32'h40,         1,   1, 32'h104,       1, 32'h100,      32'h104);
        add(1, 0, 0, 0, 0, 32'h0,          0,   1, 32'h40,        0, 32'h100,      32'h104);      // 3 wait states
        add(1, 0, 0, 0, 0, 32'h0,          0,   1, 32'h40,        0, 32'h100,      32'h104);
        add(1, 0, 0, 0, 0, 32'h0,          0,   1, 32'h40,        0, 32'h100,      32'h104);
        add(1, 0, 0, 0, 0, 32'h0,          1,   1, 32'h40,        0, 32'h100,      32'h104);
        add(1, 0, 0, 1, 1, 32'h200,        0,   1, 32'h44,        1, 32'h40,       32'h44);       // redirect while waiting
        add(1, 0, 0, 0, 0, 32'h0,          0,   1, 32'h44,        0, 32'h40,       32'h44);
        add(1, 0, 0, 0, 0, 32'h0,          1,   1, 32'h44,        0, 32'h40,       32'h44);
        add(1, 0, 0, 0, 0, 32'h0,          1,   1, 32'h200,       0, 32'h40,       32'h44);
        add(1, 0, 0, 0, 1, 32'h300,        0,   1, 32'h204,       1, 32'h200,      32'h204);      // DRAIN again
        add(1, 0, 0, 0, 1, 32'h344,        0,   1, 32'h204,       0, 32'h200,      32'h204);
        add(0, 0, 0, 0, 0, 32'h0,          1,   1, 32'h204,       0, 32'h200,      32'h204);      // reset in DRAIN
        add(1, 0, 0, 0, 0, 32'h0,          1,   0, 32'h0,         0, 32'h0,        32'h0);
        add(1, 0, 0, 0, 0, 32'h0,          1,   1, 32'h0,         0, 32'h0,        32'h0);
        add(1, 0, 0, 1, 1, 32'h500,        0,   1, 32'h4,         1, 32'h0,        32'h4);        // last redirect wins
        add(1, 0, 0, 0, 1, 32'h606,        0,   1, 32'h4,         0, 32'h0,        32'h4);
        add(1, 1, 1, 0, 0, 32'h0,          1,   1, 32'h4,         0, 32'h0,        32'h4);        // StallF cannot pin DRAIN
        add(1, 0, 0, 0, 0, 32'h0,          1,   1, 32'h604,       0, 32'h0,        32'h4);
        add(1, 0, 0, 1, 1, 32'hFFFF_FFFF,  1,   1, 32'h608,       1, 32'h604,      32'h608);      // PC+4 wrap
        add(1, 0, 0, 0, 0, 32'h0,          1,   1, 32'hFFFF_FFFC, 0, 32'h604,      32'h608);
        add(1, 0, 0, 0, 0, 32'h0,          1,   1, 32'h0,         1, 32'hFFFF_FFFC, 32'h0);
        add(1, 1, 1, 1, 1, 32'h80,         1,   1, 32'h4,         1, 32'h0,        32'h4);        // redirect beats StallF
        add(1, 0, 0, 0, 0, 32'h0,          1,   1, 32'h80,        0, 32'h0,        32'h4);
        add(1, 0, 0, 0, 0, 32'h0,          1,   1, 32'h84,        1, 32'h80,       32'h84);

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            exp_instr = vecs[i].v ? (32'h1000_0000 | vecs[i].pcd) : NOP_INSTR;
            check($sformatf("row%0d_req", i),   {31'b0, imem_req}, {31'b0, vecs[i].req});
            check($sformatf("row%0d_addr", i),  imem_addr,         vecs[i].addr);
            check($sformatf("row%0d_valid", i), {31'b0, ValidD},   {31'b0, vecs[i].v});
            check($sformatf("row%0d_pcd", i),   PCD,               vecs[i].pcd);
            check($sformatf("row%0d_pc4", i),   PCPlus4D,          vecs[i].p4);
            check($sformatf("row%0d_instr", i), InstrD,            exp_instr);
            rst = vecs[i].rst; StallF = vecs[i].sf; StallD = vecs[i].sd; FlushD = vecs[i].fd;
            PCSrcE = vecs[i].src; PCTargetE = vecs[i].tgt; imem_ready = vecs[i].rdy;
        end

        // Long wait state at 0x88: address must not move, and the word must arrive exactly once.
        @(negedge clk);
        held_addr = 32'h88;
        imem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("wait%0d_addr", c), imem_addr, held_addr);
            check($sformatf("wait%0d_valid", c), {31'b0, ValidD}, 32'h0);
        end
        imem_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            @(negedge clk);
            if (ValidD === 1'b1) seen = 1'b1;
        end
        check("wait_arrival_seen", {31'b0, seen}, 32'h1);
        check("wait_arrival_pcd", PCD, held_addr);
        check("wait_arrival_instr", InstrD, 32'h1000_0088);
        @(negedge clk);
        check("wait_next_pcd", PCD, 32'h8C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus the IF/ID pipeline register of the five-stage RV32I pipeline. Sits directly upstream of decode.
- Consumes StallF, StallD and FlushD from the hazard unit, and the redirect (PCSrcE, PCTargetE) from execute.
- Owns the PC and the instruction-memory request handshake. The handshake supports wait states, so a slow memory inserts bubbles rather than corrupting decode.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- StallF  in  1  hold the PC (load-use stall).
- StallD  in  1  hold the IF/ID register.
- FlushD  in  1  clear IF/ID to a bubble.
- PCSrcE  in  1  taken branch/jump redirect from execute.
- PCTargetE  in  XLEN  redirect target.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address; always equals PCF.
- imem_ready  in  1  memory has imem_rdata valid this cycle; transfer completes at the clock edge.
- imem_rdata  in  32  fetched instruction.
- InstrD  out  32  decode-stage instruction.
- PCD  out  XLEN  PC of InstrD.
- PCPlus4D  out  XLEN  PCD+4.
- ValidD  out  1  InstrD is a real instruction, not a bubble.

Behaviour:
- Reset (rst==0 at a clock edge):
  - PCF=RESET_PC, state=RUN, imem_req=0.
  - InstrD=32'h0000_0013 (NOP), PCD=0, PCPlus4D=0, ValidD=0.
  - Reset mid-transfer abandons the transfer; a saved redirect target is discarded.
- imem_req is registered and goes to 1 the first cycle after reset release. It then stays 1.
- Handshake:
  - imem_addr is held stable while imem_req=1 and imem_ready=0.
  - A transfer completes on any edge with imem_req=1 and imem_ready=1.
  - A memory with imem_ready tied high gives one fetch per cycle. Fetch-to-InstrD latency is 1 cycle.
- Arithmetic:
  - PC+4 wraps modulo 2^XLEN.
  - PCTargetE[1:0] is forced to 2'b00 before use.
- State RUN, PC update priority (highest first):
  1. PCSrcE=1 and imem_ready=1: PCF<=PCTargetE. The response is dropped. PCSrcE overrides StallF.
  2. PCSrcE=1 and imem_ready=0: save PCTargetE, go to DRAIN, PCF held.
  3. StallF=1: PCF held. A completed transfer is discarded and reissued next cycle (reads are idempotent).
  4. imem_ready=1: PCF<=PCF+4.
  5. Otherwise PCF held (wait state).
- State DRAIN (an old request is still outstanding):
  - PCF, and therefore imem_addr, held.
  - imem_ready=1: PCF<=saved target, go to RUN. The response is dropped.
  - A new PCSrcE in DRAIN overwrites the saved target; the last one wins.
  - StallF does not block leaving DRAIN.
- IF/ID register, per edge, priority order:
  1. Reset clears it.
  2. FlushD: bubble (NOP, ValidD=0, PCD/PCPlus4D unchanged).
  3. StallD: hold all fields.
  4. RUN and imem_ready=1 and PCSrcE=0 and StallF=0: InstrD<=imem_rdata, PCD<=PCF, PCPlus4D<=PCF+4, ValidD<=1.
  5. Otherwise: bubble. This covers wait states, DRAIN and dropped responses.
- StallF=1 with StallD=0 is illegal hazard-unit output. The bench flags it; the RTL behaviour for it is defined by the priority rules above.
- Invariant: PCSrcE=1 always implies the IF/ID register never captures the response of that cycle.

Decomposition:
- Shared package riscv_pkg holds:
  - constant NOP_INSTR = 32'h0000_0013;
  - constant default RESET_PC;
  - fetch state enum {RUN, DRAIN}.
- One sub-module, if_id_reg: the IF/ID register with reset, flush, stall and load priority.
- fetch_stage keeps the PC, the FSM, the saved target and the handshake.

Test Plan:
- Zero-wait memory, RESET_PC=0, no hazards, release reset -> imem_addr 0,4,8,C on consecutive cycles; InstrD/PCD follow 1 cycle later; ValidD=1 from the second fetch edge.
- StallF=StallD=1 for 2 cycles at PCF=0x10 -> imem_addr stays 0x10 and IF/ID holds PCD=0x0C. After release, PCD=0x10, then 0x14, with no lost or duplicated instruction.
- PCSrcE=1, FlushD=1, PCTargetE=0x103 at PCF=0x20 with zero wait -> next imem_addr=0x100; InstrD=NOP, ValidD=0 for one cycle; then PCD=0x100.
- imem_ready=0 for 3 cycles at PCF=0x40 -> imem_addr held at 0x40; three bubbles (ValidD=0); then PCD=0x40.
- Redirect to 0x200 while waiting (imem_ready=0), ready arrives 2 cycles later -> FSM enters DRAIN, imem_addr held at the old PC, response dropped; next imem_addr=0x200 and no instruction from the old stream reaches ValidD=1.
- rst=0 asserted in DRAIN with a saved target -> next cycle PCF=RESET_PC, imem_req=0, ValidD=0, saved target discarded.
